// File: rtl/obi_prefetch_fetcher.sv
// OBI instruction fetcher with a prefetch FIFO, several requests in flight, and branch
// redirect that discards responses belonging to the old instruction stream.
module obi_prefetch_fetcher #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BOOT_ADDR  = '0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              instr_rdy_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_data_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  output logic              busy_out,
  output logic              proc_req,
  output logic [ADDR_W-1:0] PC_out,
  input  logic              mem_rdy,
  input  logic              valid,
  input  logic [DATA_W-1:0] DATA_in
);

  localparam int unsigned       INC        = DATA_W / 8;
  localparam int unsigned       PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_INC   = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC - 1));
  localparam logic [CNT_W:0]    DEPTH_EXT  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {FIdle, FReq} fsm_e;

  fsm_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_addr, w_fetch_addr_nxt;
  logic [ADDR_W-1:0] r_resp_addr, w_resp_addr_nxt;
  logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
  logic              r_redirect_pend, w_redirect_pend_nxt;
  logic [CNT_W-1:0]  r_fifo_cnt, w_fifo_cnt_nxt;
  logic [CNT_W-1:0]  r_outstanding, w_outstanding_nxt;
  logic [CNT_W-1:0]  r_discard_cnt, w_discard_cnt_nxt;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];

  logic [ADDR_W-1:0] w_target;
  logic              w_grant, w_resp, w_drop_disc, w_push, w_pop, w_hold_branch;
  logic              w_credit, w_credit_nxt;

  assign w_target      = branch_addr_i & ALIGN_MASK;
  assign w_grant       = (r_state == FReq) && mem_rdy;
  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign w_resp        = valid && (r_outstanding != '0);
  assign w_drop_disc   = w_resp && (r_discard_cnt != '0);
  // A response arriving in a branch cycle belongs to the old stream.
  assign w_push        = w_resp && !w_drop_disc && !branch_i;
  assign w_pop         = instr_valid_o && instr_rdy_i && !branch_i;
  // Branch against a request the memory has not yet granted: the request must stay stable.
  assign w_hold_branch = branch_i && (r_state == FReq) && !mem_rdy;

  assign w_credit      = ({1'b0, r_fifo_cnt} + {1'b0, r_outstanding}) < DEPTH_EXT;
  assign w_credit_nxt  = ({1'b0, w_fifo_cnt_nxt} + {1'b0, w_outstanding_nxt}) < DEPTH_EXT;

  // Next-state for counters, addresses, redirect bookkeeping and the request FSM.
  always_comb begin
    w_state_nxt         = r_state;
    w_fetch_addr_nxt    = r_fetch_addr;
    w_resp_addr_nxt     = r_resp_addr;
    w_pend_addr_nxt     = r_pend_addr;
    w_redirect_pend_nxt = r_redirect_pend;

    w_outstanding_nxt = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp);

    if (branch_i) begin
      w_fifo_cnt_nxt    = '0;
      w_discard_cnt_nxt = w_outstanding_nxt;
      w_resp_addr_nxt   = w_target;
    end else begin
      w_fifo_cnt_nxt    = r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      // A held request granted after a redirect is stale as well.
      w_discard_cnt_nxt = r_discard_cnt - CNT_W'(w_drop_disc)
                          + CNT_W'(w_grant && r_redirect_pend);
      if (w_push) begin
        w_resp_addr_nxt = r_resp_addr + ADDR_INC;
      end
    end

    if (w_grant) begin
      w_fetch_addr_nxt    = r_redirect_pend ? r_pend_addr : r_fetch_addr + ADDR_INC;
      w_redirect_pend_nxt = 1'b0;
    end

    if (w_hold_branch) begin
      w_pend_addr_nxt     = w_target;
      w_redirect_pend_nxt = 1'b1;
    end else if (branch_i) begin
      w_fetch_addr_nxt    = w_target;
      w_redirect_pend_nxt = 1'b0;
    end

    unique case (r_state)
      FIdle:   if (w_credit) w_state_nxt = FReq;
      FReq:    if (w_grant && !w_credit_nxt) w_state_nxt = FIdle;
      default: w_state_nxt = FIdle;
    endcase
  end

  // Control state and FIFO pointers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state         <= FIdle;
      r_fetch_addr    <= BOOT_ADDR;
      r_resp_addr     <= BOOT_ADDR;
      r_pend_addr     <= BOOT_ADDR;
      r_redirect_pend <= 1'b0;
      r_fifo_cnt      <= '0;
      r_outstanding   <= '0;
      r_discard_cnt   <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_fetch_addr    <= w_fetch_addr_nxt;
      r_resp_addr     <= w_resp_addr_nxt;
      r_pend_addr     <= w_pend_addr_nxt;
      r_redirect_pend <= w_redirect_pend_nxt;
      r_fifo_cnt      <= w_fifo_cnt_nxt;
      r_outstanding   <= w_outstanding_nxt;
      r_discard_cnt   <= w_discard_cnt_nxt;
      if (branch_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only visible through the occupancy count, so no reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= DATA_in;
      r_fifo_addr[r_wr_ptr] <= r_resp_addr;
    end
  end

  assign proc_req      = (r_state == FReq);
  assign PC_out        = r_fetch_addr;
  assign instr_valid_o = (r_fifo_cnt != '0);
  assign busy_out      = !instr_valid_o;
  assign instr_data_o  = instr_valid_o ? r_fifo_data[r_rd_ptr] : '0;
  assign instr_addr_o  = instr_valid_o ? r_fifo_addr[r_rd_ptr] : '0;

  a_no_orphan_rvalid: assert property (@(posedge CLK) disable iff (!RSTn)
    !(valid && (r_outstanding == '0)));

endmodule

// File: tb/tb_obi_prefetch_fetcher.sv
// Bench for obi_prefetch_fetcher: in-order OBI memory model plus a stream-level reference
// model (expected fetch address, expected instruction stream, stale-transaction tracking).
module tb_obi_prefetch_fetcher;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          branch_i = 1'b0;
  logic [AW-1:0] branch_addr_i = '0;
  logic          instr_rdy_i = 1'b0;
  logic          instr_valid_o;
  logic [DW-1:0] instr_data_o;
  logic [AW-1:0] instr_addr_o;
  logic          busy_out;
  logic          proc_req;
  logic [AW-1:0] PC_out;
  logic          mem_rdy = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] DATA_in = '0;

  obi_prefetch_fetcher #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .BOOT_ADDR (BOOT)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .branch_i     (branch_i),
    .branch_addr_i(branch_addr_i),
    .instr_rdy_i  (instr_rdy_i),
    .instr_valid_o(instr_valid_o),
    .instr_data_o (instr_data_o),
    .instr_addr_o (instr_addr_o),
    .busy_out     (busy_out),
    .proc_req     (proc_req),
    .PC_out       (PC_out),
    .mem_rdy      (mem_rdy),
    .valid        (valid),
    .DATA_in      (DATA_in)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          age;
  } txn_t;

  txn_t        q[$];         // granted, not yet answered, in order
  int          lat = 0;      // extra response latency in cycles
  int          m_fcnt;       // words the FIFO must hold
  logic [31:0] m_head;       // address of the instruction at the FIFO head
  logic [31:0] m_fetch;      // address the next request must carry
  logic [31:0] m_pend_tgt;
  bit          m_pend;
  bit          m_held_stale; // the currently held request is already stale
  bit          hold_prev;
  logic [31:0] hold_pc;
  int          n_grants;
  logic [31:0] last_gnt;

  task automatic model_reset();
    q.delete();
    m_fcnt       = 0;
    m_head       = BOOT;
    m_fetch      = BOOT;
    m_pend_tgt   = BOOT;
    m_pend       = 1'b0;
    m_held_stale = 1'b0;
    hold_prev    = 1'b0;
    hold_pc      = BOOT;
    n_grants     = 0;
    last_gnt     = BOOT;
  endtask

  // Model update on every clock edge; everything is wiped by reset.
  initial begin
    txn_t        t;
    bit          push, pop;
    logic [31:0] tgt;
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) begin
        model_reset();
      end else begin
        push = 1'b0;
        if (valid && q.size() > 0) begin
          t    = q.pop_front();
          push = !t.stale && !branch_i;
        end
        pop = (m_fcnt > 0) && instr_rdy_i && !branch_i;
        if (branch_i) m_fcnt = 0;
        else          m_fcnt = m_fcnt + int'(push) - int'(pop);
        if (pop) m_head = m_head + 32'd4;
        foreach (q[i]) q[i].age++;
        hold_prev = proc_req && !mem_rdy;
        hold_pc   = PC_out;
        if (proc_req && mem_rdy) begin
          n_grants++;
          last_gnt = PC_out;
          t.addr   = PC_out;
          t.stale  = m_held_stale || branch_i;
          t.age    = 0;
          q.push_back(t);
          m_held_stale = 1'b0;
          m_fetch      = m_pend ? m_pend_tgt : m_fetch + 32'd4;
          m_pend       = 1'b0;
        end
        if (branch_i) begin
          tgt = branch_addr_i & 32'hFFFF_FFFC;
          foreach (q[i]) q[i].stale = 1'b1;
          m_head = tgt;
          if (proc_req && !mem_rdy) begin
            m_pend       = 1'b1;
            m_pend_tgt   = tgt;
            m_held_stale = 1'b1;
          end else begin
            m_fetch = tgt;
            m_pend  = 1'b0;
          end
        end
      end
    end
  end

  // In-order memory: answers the oldest transaction once it is old enough.
  initial forever begin
    @(negedge CLK or negedge RSTn);
    if (!RSTn || q.size() == 0 || q[0].age < lat) begin
      valid   = 1'b0;
      DATA_in = '0;
    end else begin
      valid   = 1'b1;
      DATA_in = word_of(q[0].addr);
    end
  end

  // Compare DUT outputs with the model every cycle out of reset.
  initial forever begin
    @(negedge CLK);
    if (RSTn) begin
      check("instr_valid", instr_valid_o, m_fcnt > 0);
      check("busy", busy_out, m_fcnt == 0);
      if (m_fcnt > 0) begin
        check("head_addr", instr_addr_o, m_head);
        check("head_data", instr_data_o, word_of(m_head));
      end
      if (proc_req) begin
        check("pc", PC_out, m_fetch);
        check("credit", (m_fcnt + q.size()) < DEPTH, 1);
      end
      if (hold_prev) begin
        check("obi_hold_req", proc_req, 1);
        check("obi_hold_pc", PC_out, hold_pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int g0;
    mem_rdy     = 1'b1;
    instr_rdy_i = 1'b1;
    #2;
    check("rst_proc_req", proc_req, 0);
    check("rst_pc", PC_out, BOOT);
    check("rst_valid", instr_valid_o, 0);
    check("rst_busy", busy_out, 1);
    check("rst_data", instr_data_o, 0);
    check("rst_addr", instr_addr_o, 0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;

    // 1: streaming, one grant per cycle, head address follows two cycles later
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("t1_req", proc_req, 1);
      check("t1_pc", PC_out, 32'(4 * k));
      if (k >= 2) check("t1_iaddr", instr_addr_o, 32'(4 * (k - 2)));
    end

    // 2: consumer stalled: exactly DEPTH grants, then one more per popped word
    RSTn = 1'b0;
    instr_rdy_i = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (15) @(negedge CLK);
    check("t2_grants", n_grants, 4);
    check("t2_req_low", proc_req, 0);
    check("t2_valid", instr_valid_o, 1);
    check("t2_head", instr_addr_o, 32'h0);
    check("t2_data", instr_data_o, 32'hDEAD_BEEF);
    instr_rdy_i = 1'b1;
    @(negedge CLK);
    instr_rdy_i = 1'b0;
    repeat (8) @(negedge CLK);
    check("t2_grants_after_pop", n_grants, 5);
    check("t2_last_gnt", last_gnt, 32'h10);
    check("t2_head_after_pop", instr_addr_o, 32'h4);
    check("t2_req_low_again", proc_req, 0);

    // 3: branch with two slow transactions in flight (0x10, 0x14)
    lat         = 4;
    instr_rdy_i = 1'b1;
    g0          = n_grants;
    branch_i      = 1'b1;
    branch_addr_i = 32'h10;
    @(negedge CLK);
    branch_i = 1'b0;
    for (int n = 0; n < 20 && n_grants < g0 + 2; n++) @(negedge CLK);
    check("t3_two_granted", n_grants >= g0 + 2, 1);
    branch_i      = 1'b1;
    branch_addr_i = 32'h103;  // low bits must be ignored
    @(negedge CLK);
    branch_i = 1'b0;
    lat      = 0;
    for (int n = 0; n < 30 && !instr_valid_o; n++) @(negedge CLK);
    check("t3_first_addr", instr_addr_o, 32'h100);
    check("t3_first_data", instr_data_o, 32'hDEAD_BFEF);

    // 4: branch while a request is held without grant
    mem_rdy = 1'b0;
    for (int n = 0; n < 20 && !proc_req; n++) @(negedge CLK);
    check("t4_req_up", proc_req, 1);
    branch_i      = 1'b1;
    branch_addr_i = 32'h20;
    @(negedge CLK);
    branch_i = 1'b0;
    mem_rdy  = 1'b1;
    @(negedge CLK);
    mem_rdy = 1'b0;
    check("t4_pc_20", PC_out, 32'h20);
    branch_i      = 1'b1;
    branch_addr_i = 32'h200;
    @(negedge CLK);
    branch_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t4_pc_held", PC_out, 32'h20);
      @(negedge CLK);
    end
    mem_rdy = 1'b1;
    @(negedge CLK);
    check("t4_pc_200", PC_out, 32'h200);
    for (int n = 0; n < 30 && !instr_valid_o; n++) @(negedge CLK);
    check("t4_first_addr", instr_addr_o, 32'h200);

    // 5: fetch address wraps with back-to-back grants
    branch_i      = 1'b1;
    branch_addr_i = 32'hFFFF_FFF8;
    @(negedge CLK);
    branch_i = 1'b0;
    for (int n = 0; n < 20 && !(proc_req && PC_out == 32'hFFFF_FFFC); n++) @(negedge CLK);
    check("t5_pc_fffc", PC_out, 32'hFFFF_FFFC);
    @(negedge CLK);
    check("t5_pc_wrap", PC_out, 32'h0);
    check("t5_req", proc_req, 1);
    repeat (6) @(negedge CLK);

    // 6: asynchronous reset in the middle of traffic
    lat = 1;
    for (int n = 0; n < 30 && !(instr_valid_o && proc_req && q.size() >= 2); n++)
      @(negedge CLK);
    check("t6_busy_traffic", instr_valid_o && proc_req && q.size() >= 2, 1);
    #2;
    RSTn = 1'b0;
    #1;
    check("t6_req_async", proc_req, 0);
    check("t6_valid_async", instr_valid_o, 0);
    check("t6_busy_async", busy_out, 1);
    check("t6_pc_async", PC_out, BOOT);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    lat  = 0;
    for (int n = 0; n < 10 && !proc_req; n++) @(negedge CLK);
    check("t6_restart_pc", PC_out, BOOT);
    for (int n = 0; n < 10 && !instr_valid_o; n++) @(negedge CLK);
    check("t6_restart_addr", instr_addr_o, BOOT);
    check("t6_restart_data", instr_data_o, 32'hDEAD_BEEF);
    repeat (4) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
